dec_onehot_scan: RTL and testbench

Parametrised registered N-to-2^N one-hot decoder with an auto-scan mode. In direct mode it registers the decode of an external select. In scan mode it walks the active output line through all 2^N positions, holding each for a programmable dwell time. It sits wherever the design drives a one-hot line select: multiplexed display digit enables, keypad row strobes, or bank select. It is the successor to the fixed 2-to-4 combinational decoder.

---
 rtl/dec_onehot_scan_pkg.sv | 25 ++
 rtl/dec_onehot_scan_if.sv | 28 ++
 rtl/dec_onehot_scan_dwell_cnt.sv | 41 ++++
 rtl/dec_onehot_scan.sv | 89 ++++++++
 tb/tb_dec_onehot_scan.sv | 134 +++++++++++++
 5 files changed

// File: rtl/dec_onehot_scan_pkg.sv
// Shared definitions for the one-hot scan decoder: mode encodings, FSM states
// and the one-hot helper used by the top level.
package dec_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Widest select the decoder supports; callers truncate onehot() to 2^N bits.
  localparam int MAX_N = 6;
  localparam int MAX_W = 1 << MAX_N;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_t;

  function automatic logic [MAX_W-1:0] onehot(input logic [MAX_N-1:0] sel);
    logic [MAX_W-1:0] r;
    r      = '0;
    r[sel] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/dec_onehot_scan_if.sv
// Control/output bundle of the one-hot scan decoder. The driver owns en/mode/i;
// the decoder owns the registered y/idx/wrap plus a debug view of its FSM state.
interface dec_onehot_scan_if #(
  parameter int N = 2
);
  import dec_pkg::*;

  // No valid/ready handshake: inputs are sampled every clk edge and every
  // output is a register updated on that same edge (1-cycle latency).
  logic           en;
  logic           mode;
  logic [N-1:0]   i;
  logic [(1<<N)-1:0] y;
  logic [N-1:0]   idx;
  logic           wrap;
  state_t         state_dbg;

  modport master (
    output en, mode, i,
    input  y, idx, wrap, state_dbg
  );

  modport slave (
    input  en, mode, i,
    output y, idx, wrap, state_dbg
  );

endinterface

// File: rtl/dec_onehot_scan_dwell_cnt.sv
// Dwell counter for scan mode: counts 0..DWELL-1 while run is high and flags
// the last count so the top level can advance to the next line.
module dec_dwell_cnt #(
  parameter int DWELL = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic run,
  output logic tick
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          at_last;

  assign at_last = (cnt_q == LAST);
  assign tick    = run && at_last;

  // clr beats run so entering a dwell always restarts a full period.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = at_last ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dec_onehot_scan.sv
// Registered N-to-2^N one-hot decoder with an auto-scan mode that walks the
// active line through every position, holding each for DWELL cycles.
module dec_onehot_scan
  import dec_pkg::*;
#(
  parameter int N     = 2,
  parameter int DWELL = 4
) (
  input  logic             clk,
  input  logic             rst,
  dec_onehot_scan_if.slave bus
);

  localparam int W = 1 << N;

  state_t         state_q, state_d;
  logic [W-1:0]   y_q, y_d;
  logic [N-1:0]   idx_q, idx_d;
  logic           wrap_q, wrap_d;
  logic [N-1:0]   idx_inc;
  logic           cnt_clr;
  logic           cnt_run;
  logic           cnt_tick;

  assign idx_inc = idx_q + N'(1);

  dec_dwell_cnt #(
    .DWELL (DWELL)
  ) u_dwell (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .run  (cnt_run),
    .tick (cnt_tick)
  );

  // en outranks mode, and mode outranks a dwell expiry: the counter only runs
  // while already scanning with scan still requested, so tick cannot fire on a
  // blanking or mode-change cycle.
  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    idx_d   = idx_q;
    wrap_d  = 1'b0;
    cnt_clr = 1'b0;
    cnt_run = 1'b0;
    if (!bus.en) begin
      state_d = IDLE;
      y_d     = '0;
    end else if (bus.mode == MODE_DIRECT) begin
      state_d = DIRECT;
      idx_d   = bus.i;
      y_d     = W'(onehot(MAX_N'(bus.i)));
      cnt_clr = 1'b1;
    end else if (state_q != SCAN) begin
      // Entering scan re-shows the current line for a full dwell.
      state_d = SCAN;
      y_d     = W'(onehot(MAX_N'(idx_q)));
      cnt_clr = 1'b1;
    end else begin
      cnt_run = 1'b1;
      if (cnt_tick) begin
        idx_d  = idx_inc;
        y_d    = W'(onehot(MAX_N'(idx_inc)));
        wrap_d = (idx_inc == '0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      y_q     <= '0;
      idx_q   <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      idx_q   <= idx_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bus.y         = y_q;
  assign bus.idx       = idx_q;
  assign bus.wrap      = wrap_q;
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_dec_onehot_scan.sv
// Directed bench for dec_onehot_scan: one N=2/DWELL=3 instance for decode,
// sweep, blanking and mode switching, one N=3/DWELL=1 instance for fast scan.
module tb_dec_onehot_scan;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  dec_onehot_scan_if #(.N(2)) bus_a ();
  dec_onehot_scan_if #(.N(3)) bus_b ();

  dec_onehot_scan #(.N(2), .DWELL(3)) u_dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (bus_a)
  );

  dec_onehot_scan #(.N(3), .DWELL(1)) u_dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (bus_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic [3:0] ey, input logic [1:0] ei, input logic ew);
    check({tag, ".y"},    32'(bus_a.y),    32'(ey));
    check({tag, ".idx"},  32'(bus_a.idx),  32'(ei));
    check({tag, ".wrap"}, 32'(bus_a.wrap), 32'(ew));
  endtask

  task automatic chk_b(input string tag, input logic [7:0] ey, input logic [2:0] ei, input logic ew);
    check({tag, ".y"},    32'(bus_b.y),    32'(ey));
    check({tag, ".idx"},  32'(bus_b.idx),  32'(ei));
    check({tag, ".wrap"}, 32'(bus_b.wrap), 32'(ew));
  endtask

  // Hand-computed N=2 DWELL=3 sweep starting at the scan-entry cycle.
  logic [3:0] sweep_y   [20] = '{4'h1, 4'h1, 4'h1, 4'h2, 4'h2, 4'h2, 4'h4, 4'h4, 4'h4, 4'h8,
                                 4'h8, 4'h8, 4'h1, 4'h1, 4'h1, 4'h2, 4'h2, 4'h2, 4'h4, 4'h4};
  logic [1:0] sweep_idx [20] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd3,
                                 2'd3, 2'd3, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2};
  logic       sweep_wr  [20] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  logic [3:0] dir_y     [4]  = '{4'h1, 4'h2, 4'h4, 4'h8};

  initial begin
    logic [7:0] ey;
    rst_a = 1'b1;
    rst_b = 1'b1;
    bus_a.en = 1'b1; bus_a.mode = 1'b1; bus_a.i = 2'd0;
    bus_b.en = 1'b0; bus_b.mode = 1'b0; bus_b.i = 3'd0;

    // Reset held with en=1/mode=scan: outputs stay cleared.
    step(); chk_a("rst1", 4'h0, 2'd0, 1'b0);
    step(); chk_a("rst2", 4'h0, 2'd0, 1'b0);
    rst_a = 1'b0;
    step(); chk_a("rst_exit", 4'h1, 2'd0, 1'b0);

    // Direct decode, one cycle per select.
    bus_a.mode = 1'b0;
    for (int v = 0; v < 4; v++) begin
      bus_a.i = 2'(v);
      step(); chk_a($sformatf("direct%0d", v), dir_y[v], 2'(v), 1'b0);
    end

    // Full sweep from idx=0; i is moved to show it is ignored in scan.
    bus_a.i = 2'd0;
    step(); chk_a("dir0", 4'h1, 2'd0, 1'b0);
    bus_a.mode = 1'b1;
    bus_a.i = 2'd2;
    for (int k = 0; k < 20; k++) begin
      step(); chk_a($sformatf("sweep%0d", k), sweep_y[k], sweep_idx[k], sweep_wr[k]);
    end

    // Blank during the 2nd cycle of line 0100, then re-enable.
    bus_a.en = 1'b0;
    step(); chk_a("blank", 4'h0, 2'd2, 1'b0);
    step(); chk_a("blank_hold", 4'h0, 2'd2, 1'b0);
    bus_a.en = 1'b1;
    step(); chk_a("reen0", 4'h4, 2'd2, 1'b0);
    step(); chk_a("reen1", 4'h4, 2'd2, 1'b0);
    step(); chk_a("reen2", 4'h4, 2'd2, 1'b0);
    step(); chk_a("reen_adv", 4'h8, 2'd3, 1'b0);

    // Switch to direct on the dwell-expiry cycle of line 3.
    step(); chk_a("msw_c1", 4'h8, 2'd3, 1'b0);
    step(); chk_a("msw_c2", 4'h8, 2'd3, 1'b0);
    bus_a.mode = 1'b0;
    bus_a.i = 2'd3;
    step(); chk_a("msw_dir", 4'h8, 2'd3, 1'b0);
    bus_a.mode = 1'b1;
    step(); chk_a("msw_scan0", 4'h8, 2'd3, 1'b0);
    step(); chk_a("msw_scan1", 4'h8, 2'd3, 1'b0);
    step(); chk_a("msw_scan2", 4'h8, 2'd3, 1'b0);
    step(); chk_a("msw_wrap", 4'h1, 2'd0, 1'b1);
    step(); chk_a("msw_after", 4'h1, 2'd0, 1'b0);

    // N=3, DWELL=1: one line per cycle, wrap once per 8 cycles.
    chk_b("b_rst", 8'h00, 3'd0, 1'b0);
    rst_b = 1'b0;
    bus_b.en = 1'b1;
    bus_b.mode = 1'b1;
    step(); chk_b("b_entry", 8'h01, 3'd0, 1'b0);
    for (int k = 1; k < 20; k++) begin
      ey = 8'h01 << (k % 8);
      step(); chk_b($sformatf("b_scan%0d", k), ey, 3'(k % 8), (k % 8) == 0);
    end
    rst_b = 1'b1;
    step(); chk_b("b_rst_mid", 8'h00, 3'd0, 1'b0);
    step(); chk_b("b_rst_hold", 8'h00, 3'd0, 1'b0);
    rst_b = 1'b0;
    step(); chk_b("b_rst_exit", 8'h01, 3'd0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
